// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display scanner.
// Blank pattern, low-active glyph table and counter width helper.
package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index d holds the low-active {g,f,e,d,c,b,a} glyph for hex digit d.
  localparam logic [15:0][6:0] GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int cnt_w(input int range);
    return (range < 2) ? 1 : $clog2(range);
  endfunction

endpackage

// File: rtl/hex_display_scan_seg7_decode.sv
// Hex digit to low-active 7-segment glyph lookup.
// Ports: digit (4-bit hex in), seg (7-bit {g..a} low-active out).
module seg7_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = GLYPH[digit];

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed N-digit 7-segment scanner with blanking, LZS, blink.
// Ports: clk, rst_n, value, blink_mask, lzs_en, load -> seg, dig_sel, frame_done.
module hex_display_scan
  import hex_display_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  lzs_en,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   dig_sel,
  output logic                  frame_done
);

  localparam int SW = cnt_w(CLK_DIV);
  localparam int IW = cnt_w(N_DIGITS);
  localparam int FW = cnt_w(BLINK_FRAMES);
  localparam int VW = 4 * N_DIGITS;

  localparam logic [SW-1:0] SLOT_LAST = SW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0] BF_LAST   = FW'(BLINK_FRAMES - 1);

  logic [SW-1:0]       slot_cnt;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       bf_cnt;
  logic                blink_off;

  logic [VW-1:0]       act_val;
  logic [N_DIGITS-1:0] act_mask;
  logic                act_lzs;
  logic [VW-1:0]       pend_val;
  logic [N_DIGITS-1:0] pend_mask;
  logic                pend_lzs;
  logic                pend_valid;

  logic                slot_end;
  logic                frame_end;
  logic                ghost;
  logic                zero_run;
  logic [N_DIGITS-1:0] lzs_blank;
  logic [N_DIGITS-1:0] sel_n;
  logic [3:0]          cur_digit;
  logic                cur_blink;
  logic                cur_lzs;
  logic [6:0]          glyph;

  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_cnt    <= '0;
      blink_off <= 1'b0;
    end else if (frame_end) begin
      if (bf_cnt == BF_LAST) begin
        bf_cnt    <= '0;
        blink_off <= ~blink_off;
      end else begin
        bf_cnt <= bf_cnt + FW'(1);
      end
    end
  end

  // Active set only changes on a frame boundary so a frame never
  // mixes digits from two loads; a load on the boundary bypasses
  // the shadow copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_val    <= '0;
      act_mask   <= '0;
      act_lzs    <= 1'b0;
      pend_val   <= '0;
      pend_mask  <= '0;
      pend_lzs   <= 1'b0;
      pend_valid <= 1'b0;
    end else if (load) begin
      if (frame_end) begin
        act_val    <= value;
        act_mask   <= blink_mask;
        act_lzs    <= lzs_en;
        pend_valid <= 1'b0;
      end else begin
        pend_val   <= value;
        pend_mask  <= blink_mask;
        pend_lzs   <= lzs_en;
        pend_valid <= 1'b1;
      end
    end else if (frame_end && pend_valid) begin
      act_val    <= pend_val;
      act_mask   <= pend_mask;
      act_lzs    <= pend_lzs;
      pend_valid <= 1'b0;
    end
  end

  // Walk down from the top digit; digit 0 is never suppressed.
  always_comb begin
    zero_run  = 1'b1;
    lzs_blank = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_run     = zero_run && (act_val[4*k +: 4] == 4'h0);
      lzs_blank[k] = act_lzs && zero_run;
    end
  end

  always_comb begin
    cur_digit = 4'h0;
    cur_blink = 1'b0;
    cur_lzs   = 1'b0;
    sel_n     = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_digit = act_val[4*k +: 4];
        cur_blink = act_mask[k];
        cur_lzs   = lzs_blank[k];
        sel_n[k]  = 1'b0;
      end
    end
  end

  seg7_decode u_dec (
    .digit(cur_digit),
    .seg  (glyph)
  );

  if (BLANK_CYC > 0) begin : g_ghost
    localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYC);
    assign ghost = (slot_cnt < BLANK_END);
  end else begin : g_no_ghost
    assign ghost = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_BLANK;
      dig_sel    <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (ghost) begin
        seg     <= SEG_BLANK;
        dig_sel <= '1;
      end else begin
        dig_sel <= sel_n;
        seg     <= (cur_lzs || (blink_off && cur_blink)) ? SEG_BLANK : glyph;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scan.sv
// Self-checking bench for hex_display_scan (4 digits, 4 cycles/slot).
// Expected slot patterns are queued on load and compared per frame.
module tb_hex_display_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  blink_mask = '0;
  logic        lzs_en = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
  } exp_t;

  exp_t sb[$];

  logic [6:0] gl[16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [6:0] g_seg[4];
  logic [3:0] g_dig[4];
  logic [6:0] v_seg[4][3];
  logic [3:0] v_dig[4][3];
  int         fd_mid;
  logic       fd_end;

  hex_display_scan #(
    .N_DIGITS    (4),
    .CLK_DIV     (4),
    .BLANK_CYC   (1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .blink_mask(blink_mask),
    .lzs_en    (lzs_en),
    .load      (load),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input logic [15:0] v, input logic lz,
                            input logic [3:0] m, input logic off);
    exp_t e;
    logic [15:0] hi;
    logic blank;
    for (int k = 0; k < 4; k++) begin
      hi = v >> (4 * k);
      blank = (lz && k != 0 && hi == 16'h0) || (off && m[k]);
      e.dig = 4'hF;
      e.dig[k] = 1'b0;
      e.seg = blank ? 7'h7F : gl[hi[3:0]];
      sb.push_back(e);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] m,
                         input logic lz);
    @(negedge clk);
    value = v;
    blink_mask = m;
    lzs_en = lz;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: frame_done=0 for 40 cycles, required 1", tag);
    end
  endtask

  task automatic scan_frame();
    fd_mid = 0;
    fd_end = 1'b0;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      g_seg[d] = seg;
      g_dig[d] = dig_sel;
      if (frame_done) fd_mid++;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        v_seg[d][c] = seg;
        v_dig[d][c] = dig_sel;
        if (d == 3 && c == 2) fd_end = frame_done;
        else if (frame_done) fd_mid++;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    #1 rst_n = 1'b0;
    #12;
    checks++;
    if (seg !== 7'h7F || dig_sel !== 4'hF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: seg=%h dig=%b fd=%b, required 7f 1111 0",
               seg, dig_sel, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame("reset");
    push_frame(16'h0000, 1'b0, 4'h0, 1'b0);
    scan_frame();
    for (int d = 0; d < 4; d++) begin
      e = sb.pop_front();
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (v_dig[d][c] !== e.dig || v_seg[d][c] !== e.seg) begin
          errors++;
          $display("FAIL reset_zero d%0d c%0d: got %b/%h, required %b/%h",
                   d, c, v_dig[d][c], v_seg[d][c], e.dig, e.seg);
        end
      end
    end
  endtask

  task automatic test_basic();
    exp_t e;
    do_load(16'h12AF, 4'h0, 1'b0);
    wait_frame("basic");
    for (int f = 0; f < 2; f++) begin
      push_frame(16'h12AF, 1'b0, 4'h0, 1'b0);
      scan_frame();
      for (int d = 0; d < 4; d++) begin
        e = sb.pop_front();
        checks++;
        if (g_dig[d] !== 4'hF || g_seg[d] !== 7'h7F) begin
          errors++;
          $display("FAIL basic_ghost d%0d: got %b/%h, required 1111/7f",
                   d, g_dig[d], g_seg[d]);
        end
        for (int c = 0; c < 3; c++) begin
          checks++;
          if (v_dig[d][c] !== e.dig || v_seg[d][c] !== e.seg) begin
            errors++;
            $display("FAIL basic_slot d%0d c%0d: got %b/%h, required %b/%h",
                     d, c, v_dig[d][c], v_seg[d][c], e.dig, e.seg);
          end
        end
      end
      checks++;
      if (fd_mid !== 0 || fd_end !== 1'b1) begin
        errors++;
        $display("FAIL basic_frame_done: mid=%0d end=%b, required 0 and 1",
                 fd_mid, fd_end);
      end
    end
  endtask

  task automatic test_lzs();
    exp_t e;
    logic [15:0] vals[3] = '{16'h0030, 16'h0000, 16'h0100};
    for (int t = 0; t < 3; t++) begin
      do_load(vals[t], 4'h0, 1'b1);
      wait_frame("lzs");
      push_frame(vals[t], 1'b1, 4'h0, 1'b0);
      scan_frame();
      for (int d = 0; d < 4; d++) begin
        e = sb.pop_front();
        for (int c = 0; c < 3; c++) begin
          checks++;
          if (v_dig[d][c] !== e.dig || v_seg[d][c] !== e.seg) begin
            errors++;
            $display("FAIL lzs_%h d%0d c%0d: got %b/%h, required %b/%h",
                     vals[t], d, c, v_dig[d][c], v_seg[d][c], e.dig, e.seg);
          end
        end
      end
    end
  endtask

  task automatic test_blink();
    exp_t e;
    logic off;
    do_load(16'h12AF, 4'b0001, 1'b0);
    wait_frame("blink");
    for (int f = 0; f < 5; f++) begin
      off = (((cyc / 16) / 2) % 2) == 1;
      push_frame(16'h12AF, 1'b0, 4'b0001, off);
      scan_frame();
      for (int d = 0; d < 4; d++) begin
        e = sb.pop_front();
        checks++;
        if (v_dig[d][1] !== e.dig || v_seg[d][1] !== e.seg) begin
          errors++;
          $display("FAIL blink f%0d d%0d: got %b/%h, required %b/%h",
                   f, d, v_dig[d][1], v_seg[d][1], e.dig, e.seg);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_load(16'hABCD, 4'h0, 1'b0);
    wait_frame("b2b");
    push_frame(16'hABCD, 1'b0, 4'h0, 1'b0);
    push_frame(16'h2222, 1'b0, 4'h0, 1'b0);
    for (int f = 0; f < 2; f++) begin
      if (f == 0) begin
        fork
          scan_frame();
          begin
            repeat (2) @(negedge clk);
            value = 16'h1111;
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            repeat (2) @(negedge clk);
            value = 16'h2222;
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
          end
        join
      end else begin
        scan_frame();
      end
      for (int d = 0; d < 4; d++) begin
        e = sb.pop_front();
        for (int c = 0; c < 3; c++) begin
          checks++;
          if (v_dig[d][c] !== e.dig || v_seg[d][c] !== e.seg) begin
            errors++;
            $display("FAIL b2b f%0d d%0d c%0d: got %b/%h, required %b/%h",
                     f, d, c, v_dig[d][c], v_seg[d][c], e.dig, e.seg);
          end
        end
      end
    end
  endtask

  task automatic test_boundary_load();
    exp_t e;
    push_frame(16'h2222, 1'b0, 4'h0, 1'b0);
    push_frame(16'h5555, 1'b0, 4'h0, 1'b0);
    for (int f = 0; f < 2; f++) begin
      if (f == 0) begin
        fork
          scan_frame();
          begin
            repeat (15) @(negedge clk);
            value = 16'h5555;
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
          end
        join
      end else begin
        scan_frame();
      end
      for (int d = 0; d < 4; d++) begin
        e = sb.pop_front();
        for (int c = 0; c < 3; c++) begin
          checks++;
          if (v_dig[d][c] !== e.dig || v_seg[d][c] !== e.seg) begin
            errors++;
            $display("FAIL edge_load f%0d d%0d c%0d: got %b/%h, required %b/%h",
                     f, d, c, v_dig[d][c], v_seg[d][c], e.dig, e.seg);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    wait_frame("areset");
    do_load(16'h7777, 4'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (seg !== 7'h7F || dig_sel !== 4'hF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL areset_out: seg=%h dig=%b fd=%b, required 7f 1111 0",
               seg, dig_sel, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame("areset");
    push_frame(16'h0000, 1'b0, 4'h0, 1'b0);
    scan_frame();
    for (int d = 0; d < 4; d++) begin
      e = sb.pop_front();
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (v_dig[d][c] !== e.dig || v_seg[d][c] !== e.seg) begin
          errors++;
          $display("FAIL areset_zero d%0d c%0d: got %b/%h, required %b/%h",
                   d, c, v_dig[d][c], v_seg[d][c], e.dig, e.seg);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lzs();
    test_blink();
    test_back_to_back();
    test_boundary_load();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
